alu_4bit: RTL and testbench



---
 rtl/alu_4bit.sv | 95 +++++++++
 tb/tb_alu_4bit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_4bit.sv
// 4-bit 74181-style ALU: 16 logic and 16 arithmetic functions, registered result and carry-out.
module alu_4bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       m,
    input  logic [3:0] s,
    output logic       cout,
    output logic [3:0] f
);

    localparam int unsigned W     = 4;
    localparam int unsigned SUM_W = W + 1;

    logic [W-1:0]     logic_c;
    logic [W-1:0]     x_c;
    logic [W-1:0]     y_c;
    logic [SUM_W-1:0] sum_c;
    logic [W-1:0]     f_c;
    logic             cout_c;

    // Logic-mode function table
    always_comb begin
        logic_c = '0;
        unique case (s)
            4'b0000: logic_c = ~a;
            4'b0001: logic_c = ~(a | b);
            4'b0010: logic_c = ~a & b;
            4'b0011: logic_c = '0;
            4'b0100: logic_c = ~(a & b);
            4'b0101: logic_c = ~b;
            4'b0110: logic_c = a ^ b;
            4'b0111: logic_c = a & ~b;
            4'b1000: logic_c = ~a | b;
            4'b1001: logic_c = ~(a ^ b);
            4'b1010: logic_c = b;
            4'b1011: logic_c = a & b;
            4'b1100: logic_c = '1;
            4'b1101: logic_c = a | ~b;
            4'b1110: logic_c = a | b;
            4'b1111: logic_c = a;
            default: logic_c = '0;
        endcase
    end

    // Arithmetic-mode addend selection; the sum is X + Y + cin
    always_comb begin
        x_c = '0;
        y_c = '0;
        unique case (s)
            4'b0000: begin x_c = a;          y_c = '0;      end
            4'b0001: begin x_c = a | b;      y_c = '0;      end
            4'b0010: begin x_c = a | ~b;     y_c = '0;      end
            4'b0011: begin x_c = '0;         y_c = '1;      end
            4'b0100: begin x_c = a;          y_c = a & ~b;  end
            4'b0101: begin x_c = a | b;      y_c = a & ~b;  end
            4'b0110: begin x_c = a;          y_c = ~b;      end
            4'b0111: begin x_c = a & ~b;     y_c = '1;      end
            4'b1000: begin x_c = a;          y_c = a & b;   end
            4'b1001: begin x_c = a;          y_c = b;       end
            4'b1010: begin x_c = a | ~b;     y_c = a & b;   end
            4'b1011: begin x_c = a & b;      y_c = '1;      end
            4'b1100: begin x_c = a;          y_c = a;       end
            4'b1101: begin x_c = a | b;      y_c = a;       end
            4'b1110: begin x_c = a | ~b;     y_c = a;       end
            4'b1111: begin x_c = a;          y_c = '1;      end
            default: begin x_c = '0;         y_c = '0;      end
        endcase
    end

    assign sum_c = SUM_W'(x_c) + SUM_W'(y_c) + SUM_W'(cin);

    // Mode mux: logic mode never produces a carry
    always_comb begin
        f_c    = sum_c[W-1:0];
        cout_c = sum_c[W];
        if (m) begin
            f_c    = logic_c;
            cout_c = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f    <= '0;
            cout <= 1'b0;
        end else begin
            f    <= f_c;
            cout <= cout_c;
        end
    end

endmodule

// File: tb/tb_alu_4bit.sv
// Scoreboard bench for alu_4bit: directed, exhaustive and random vectors against an arithmetic reference model.
module tb_alu_4bit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       cin = 1'b0;
    logic       m = 1'b0;
    logic [3:0] s = '0;
    logic       cout;
    logic [3:0] f;

    typedef struct {
        int   aa, bb, c, mm, ss;
        logic [3:0] ef;
        logic       ec;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    alu_4bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .m     (m),
        .s     (s),
        .cout  (cout),
        .f     (f)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic, complement of a nibble is 15 - v
    function automatic exp_t model(int aa, int bb, int c, int mm, int ss);
        exp_t e;
        int na, nb, r, x, y, sum;
        na = 15 - aa;
        nb = 15 - bb;
        r = 0; x = 0; y = 0;
        e.aa = aa; e.bb = bb; e.c = c; e.mm = mm; e.ss = ss;
        if (mm == 1) begin
            case (ss)
                0:  r = na;
                1:  r = 15 - (aa | bb);
                2:  r = na & bb;
                3:  r = 0;
                4:  r = 15 - (aa & bb);
                5:  r = nb;
                6:  r = aa ^ bb;
                7:  r = aa & nb;
                8:  r = na | bb;
                9:  r = 15 - (aa ^ bb);
                10: r = bb;
                11: r = aa & bb;
                12: r = 15;
                13: r = aa | nb;
                14: r = aa | bb;
                default: r = aa;
            endcase
            e.ef = 4'(r);
            e.ec = 1'b0;
        end else begin
            case (ss)
                0:  begin x = aa;        y = 0;       end
                1:  begin x = aa | bb;   y = 0;       end
                2:  begin x = aa | nb;   y = 0;       end
                3:  begin x = 0;         y = 15;      end
                4:  begin x = aa;        y = aa & nb; end
                5:  begin x = aa | bb;   y = aa & nb; end
                6:  begin x = aa;        y = nb;      end
                7:  begin x = aa & nb;   y = 15;      end
                8:  begin x = aa;        y = aa & bb; end
                9:  begin x = aa;        y = bb;      end
                10: begin x = aa | nb;   y = aa & bb; end
                11: begin x = aa & bb;   y = 15;      end
                12: begin x = aa;        y = aa;      end
                13: begin x = aa | bb;   y = aa;      end
                14: begin x = aa | nb;   y = aa;      end
                default: begin x = aa;   y = 15;      end
            endcase
            sum  = x + y + c;
            e.ef = 4'(sum % 16);
            e.ec = (sum >= 16);
        end
        return e;
    endfunction

    task automatic check(string name, logic [3:0] gf, logic gc, logic [3:0] ef, logic ec);
        vectors++;
        if (gf !== ef || gc !== ec) begin
            miscompares++;
            $display("FAIL %s: got f=%b cout=%b, expected f=%b cout=%b", name, gf, gc, ef, ec);
        end
    endtask

    task automatic drive(int aa, int bb, int c, int mm, int ss);
        a   = 4'(aa);
        b   = 4'(bb);
        cin = 1'(c);
        m   = 1'(mm);
        s   = 4'(ss);
        q.push_back(model(aa, bb, c, mm, ss));
    endtask

    task automatic apply(int aa, int bb, int c, int mm, int ss);
        @(negedge clk);
        drive(aa, bb, c, mm, ss);
    endtask

    // Monitor: every output update is compared against the oldest pending expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check($sformatf("op a=%0d b=%0d cin=%0d m=%0d s=%0d", e.aa, e.bb, e.c, e.mm, e.ss),
                      f, cout, e.ef, e.ec);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset asserted between edges clears outputs immediately and holds them
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", f, cout, 4'b0000, 1'b0);
        a = 4'hF; b = 4'h1; s = 4'b1001; m = 1'b0; cin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", f, cout, 4'b0000, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        drive(2, 1, 0, 0, 0);

        // Arithmetic sweep
        apply(2, 5, 1, 0, 1);
        apply(2, 3, 1, 0, 2);
        apply(2, 5, 0, 0, 3);
        apply(2, 5, 1, 0, 4);
        // Logic sweep, cin=1 must be ignored
        apply(2, 1, 1, 1, 5);
        apply(2, 1, 1, 1, 6);
        apply(2, 1, 1, 1, 9);
        apply(2, 1, 1, 1, 11);
        apply(2, 1, 1, 1, 12);
        // Carry and subtract
        apply(15, 1, 0, 0, 9);
        apply(5, 3, 1, 0, 6);
        apply(3, 5, 1, 0, 6);

        // Back-to-back select changes, then reset mid-stream discards the pending op
        for (int i = 0; i < 16; i++) apply(9, 6, i & 1, 0, i);
        apply(15, 1, 1, 0, 9);
        apply(5, 3, 1, 0, 6);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("reset_mid_async", f, cout, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        check("reset_mid_hold", f, cout, 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(7, 7, 1, 0, 12);

        // Exhaustive sweep of every input combination
        for (int i = 0; i < 16384; i++)
            apply(i & 15, (i >> 4) & 15, (i >> 8) & 1, (i >> 9) & 1, (i >> 10) & 15);

        // Random vectors
        for (int i = 0; i < 2000; i++)
            apply(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)));

        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
